// File: rtl/param_register_file.sv
// Multi-port register file with write-first bypass and a per-register
// pending-write scoreboard used by decode to detect unresolved producers.
module param_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned READ_PORTS = 2,
    parameter int unsigned PEND_WIDTH = 2,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] readAddress,
    output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
    output logic [READ_PORTS-1:0]            readBusy,
    input  logic                             regWrite,
    input  logic [ADDR_WIDTH-1:0]            writeAddress,
    input  logic [DATA_WIDTH-1:0]            writeData,
    input  logic                             reserve,
    input  logic [ADDR_WIDTH-1:0]            reserveAddress,
    output logic                             reserveStall
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [PEND_WIDTH-1:0] pend [DEPTH];

    logic wr_zero;
    logic wr_en;
    logic rsv_zero;
    logic rsv_same;
    logic rsv_inc;
    logic wr_dec;

    assign wr_zero  = ZERO_REG && (writeAddress == '0);
    assign wr_en    = regWrite && !wr_zero;
    assign rsv_zero = ZERO_REG && (reserveAddress == '0);
    // A reserve paired with a retiring write to the same register nets to zero.
    assign rsv_same = reserve && regWrite && (reserveAddress == writeAddress);

    assign reserveStall = resetN && reserve && !rsv_zero && !rsv_same
                          && (pend[reserveAddress] == PEND_MAX);
    assign rsv_inc      = reserve && !rsv_zero && !rsv_same
                          && (pend[reserveAddress] != PEND_MAX);
    assign wr_dec       = wr_en && !rsv_same && (pend[writeAddress] != '0);

    // Register storage
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[writeAddress] <= writeData;
        end
    end

    // Pending-write scoreboard; reserve and retire never target the same entry here
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pend[i] <= '0;
            end
        end else begin
            if (rsv_inc) begin
                pend[reserveAddress] <= pend[reserveAddress] + PEND_WIDTH'(1);
            end
            if (wr_dec) begin
                pend[writeAddress] <= pend[writeAddress] - PEND_WIDTH'(1);
            end
        end
    end

    // Read ports: zero register, then bypass, then storage
    for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_port
        logic [ADDR_WIDTH-1:0] addr;
        logic                  zero;
        logic                  hit;

        assign addr = readAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero = ZERO_REG && (addr == '0);
        assign hit  = regWrite && (writeAddress == addr);

        assign readData[p*DATA_WIDTH +: DATA_WIDTH] =
            (!resetN || zero) ? '0 : (hit ? writeData : regs[addr]);
        assign readBusy[p] = resetN && !zero && (pend[addr] != PEND_WIDTH'(hit));
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file built with four read ports.
module tb_param_register_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned RP = 4;

    logic              clk = 1'b0;
    logic              resetN;
    logic [RP*AW-1:0]  readAddress;
    logic [RP*DW-1:0]  readData;
    logic [RP-1:0]     readBusy;
    logic              regWrite;
    logic [AW-1:0]     writeAddress;
    logic [DW-1:0]     writeData;
    logic              reserve;
    logic [AW-1:0]     reserveAddress;
    logic              reserveStall;

    logic [AW-1:0]     ra [RP];
    int                checks   = 0;
    int                failures = 0;

    assign readAddress = {ra[3], ra[2], ra[1], ra[0]};

    param_register_file #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP),
        .PEND_WIDTH(2), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .resetN(resetN),
        .readAddress(readAddress), .readData(readData), .readBusy(readBusy),
        .regWrite(regWrite), .writeAddress(writeAddress), .writeData(writeData),
        .reserve(reserve), .reserveAddress(reserveAddress),
        .reserveStall(reserveStall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return readData[p*DW +: DW];
    endfunction

    initial begin
        resetN = 1'b0; regWrite = 1'b0; writeAddress = '0; writeData = '0;
        reserve = 1'b0; reserveAddress = '0;
        for (int i = 0; i < int'(RP); i++) ra[i] = '0;
        #3;
        check("rst_stall", 64'(reserveStall), 64'd0);
        #10;
        resetN = 1'b1;
        tick();

        // Every address reads 0 and idle after reset
        for (int a = 0; a < 32; a++) begin
            ra[0] = AW'(a);
            #1;
            check($sformatf("rst_data_r%0d", a), 64'(rd(0)), 64'd0);
            check($sformatf("rst_busy_r%0d", a), 64'(readBusy[0]), 64'd0);
        end

        // Mid-run asynchronous reset wipes r5
        regWrite = 1'b1; writeAddress = 5'd5; writeData = 32'hDEADBEEF;
        tick();
        regWrite = 1'b0; ra[0] = 5'd5;
        #1 check("r5_written", 64'(rd(0)), 64'hDEADBEEF);
        #1 resetN = 1'b0;
        #1 check("r5_async_rst", 64'(rd(0)), 64'd0);
        resetN = 1'b1;
        tick();
        check("r5_after_rst", 64'(rd(0)), 64'd0);

        // Write-first bypass on r7
        ra[0] = 5'd7; regWrite = 1'b1; writeAddress = 5'd7; writeData = 32'h12345678;
        #1 check("r7_bypass", 64'(rd(0)), 64'h12345678);
        tick();
        regWrite = 1'b0;
        #1 check("r7_stored1", 64'(rd(0)), 64'h12345678);
        tick();
        check("r7_stored2", 64'(rd(0)), 64'h12345678);

        // r0 ignores writes
        ra[0] = 5'd0; regWrite = 1'b1; writeAddress = 5'd0; writeData = 32'hFFFFFFFF;
        #1 check("r0_bypass", 64'(rd(0)), 64'd0);
        check("r0_busy", 64'(readBusy[0]), 64'd0);
        tick();
        regWrite = 1'b0;
        #1 check("r0_stored", 64'(rd(0)), 64'd0);

        // Reserve r3, retire it four cycles later
        ra[0] = 5'd3; reserve = 1'b1; reserveAddress = 5'd3;
        #1 check("r3_busy_c0", 64'(readBusy[0]), 64'd0);
        tick();
        reserve = 1'b0;
        #1 check("r3_busy_c1", 64'(readBusy[0]), 64'd1);
        tick(); tick(); tick();
        check("r3_busy_c4", 64'(readBusy[0]), 64'd1);
        tick();
        regWrite = 1'b1; writeAddress = 5'd3; writeData = 32'hA5;
        #1 check("r3_c5_data", 64'(rd(0)), 64'hA5);
        check("r3_c5_busy", 64'(readBusy[0]), 64'd0);
        tick();
        regWrite = 1'b0;
        #1 check("r3_c6_busy", 64'(readBusy[0]), 64'd0);
        check("r3_c6_data", 64'(rd(0)), 64'hA5);

        // Saturate r9, fourth reserve stalls
        ra[0] = 5'd9; reserve = 1'b1; reserveAddress = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("r9_rsv%0d_stall", i), 64'(reserveStall), 64'd0);
            tick();
        end
        #1 check("r9_rsv3_stall", 64'(reserveStall), 64'd1);
        tick();
        reserve = 1'b0;
        #1 check("r9_busy_sat", 64'(readBusy[0]), 64'd1);
        regWrite = 1'b1; writeAddress = 5'd9;
        writeData = 32'h91;
        #1 check("r9_wr1_busy", 64'(readBusy[0]), 64'd1);
        tick();
        writeData = 32'h92;
        #1 check("r9_wr2_busy", 64'(readBusy[0]), 64'd1);
        tick();
        writeData = 32'h93;
        #1 check("r9_wr3_busy", 64'(readBusy[0]), 64'd0);
        check("r9_wr3_data", 64'(rd(0)), 64'h93);
        tick();
        regWrite = 1'b0;
        #1 check("r9_idle_busy", 64'(readBusy[0]), 64'd0);
        regWrite = 1'b1; writeData = 32'h94;
        tick();
        regWrite = 1'b0;
        #1 check("r9_wr4_data", 64'(rd(0)), 64'h94);
        check("r9_wr4_busy", 64'(readBusy[0]), 64'd0);

        // Reserve r4 to max, then reserve+write same cycle
        ra[0] = 5'd4; reserve = 1'b1; reserveAddress = 5'd4;
        tick(); tick(); tick();
        regWrite = 1'b1; writeAddress = 5'd4; writeData = 32'h44;
        #1 check("r4_same_stall", 64'(reserveStall), 64'd0);
        check("r4_same_bypass", 64'(rd(0)), 64'h44);
        tick();
        reserve = 1'b0; regWrite = 1'b0;
        #1 check("r4_stored", 64'(rd(0)), 64'h44);
        check("r4_busy", 64'(readBusy[0]), 64'd1);
        regWrite = 1'b1; writeData = 32'h45;
        tick();
        #1 check("r4_cnt_after1", 64'(readBusy[0]), 64'd1);
        tick();
        #1 check("r4_cnt_last", 64'(readBusy[0]), 64'd0);
        tick();
        regWrite = 1'b0;

        // Reserve and write to different registers independently
        ra[0] = 5'd10; ra[1] = 5'd9;
        reserve = 1'b1; reserveAddress = 5'd10;
        regWrite = 1'b1; writeAddress = 5'd9; writeData = 32'h99;
        tick();
        reserve = 1'b0; regWrite = 1'b0;
        #1 check("r10_busy", 64'(readBusy[0]), 64'd1);
        check("r9_indep_data", 64'(rd(1)), 64'h99);
        check("r9_indep_busy", 64'(readBusy[1]), 64'd0);

        // Reserves to r0 are ignored
        ra[0] = 5'd0; reserve = 1'b1; reserveAddress = 5'd0;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("r0_rsv%0d_stall", i), 64'(reserveStall), 64'd0);
            tick();
        end
        reserve = 1'b0;
        #1 check("r0_rsv_busy", 64'(readBusy[0]), 64'd0);

        // Four ports concurrently, write to r2 in flight
        regWrite = 1'b1; writeAddress = 5'd1; writeData = 32'h11;
        tick();
        regWrite = 1'b0;
        reserve = 1'b1; reserveAddress = 5'd1;
        tick();
        reserveAddress = 5'd2;
        tick();
        reserve = 1'b0;
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd1; ra[3] = 5'd0;
        regWrite = 1'b1; writeAddress = 5'd2; writeData = 32'h22;
        #1;
        check("p0_data", 64'(rd(0)), 64'h11);
        check("p0_busy", 64'(readBusy[0]), 64'd1);
        check("p1_data", 64'(rd(1)), 64'h22);
        check("p1_busy", 64'(readBusy[1]), 64'd0);
        check("p2_data", 64'(rd(2)), 64'h11);
        check("p2_busy", 64'(readBusy[2]), 64'd1);
        check("p3_data", 64'(rd(3)), 64'd0);
        check("p3_busy", 64'(readBusy[3]), 64'd0);
        tick();
        regWrite = 1'b0;
        #1 check("p1_stored", 64'(rd(1)), 64'h22);

        // Reset clears the scoreboard as well as data
        resetN = 1'b0;
        #1 check("rst_busy_vec", 64'(readBusy), 64'd0);
        check("rst_p0_data", 64'(rd(0)), 64'd0);
        resetN = 1'b1;
        tick();
        check("post_rst_busy", 64'(readBusy), 64'd0);
        check("post_rst_r1", 64'(rd(0)), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised multi-read-port register file with write-first bypass and a per-register pending-write scoreboard, for the pipelined datapath's decode stage. Decode reserves a destination at issue. Writeback retires it. Each read port reports both data and a busy flag, so hazard logic can stall on unresolved producers without tracking them separately. Register 0 is optionally hardwired to zero.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- READ_PORTS, 2, number of independent read ports (1..8)
- PEND_WIDTH, 2, width of each pending-write counter; max outstanding = 2**PEND_WIDTH-1
- ZERO_REG, 1, 1 = register 0 reads 0, never written, never busy
- clk  in  1  clock, all state updates on rising edge
- resetN  in  1  reset, asynchronous, active-low
- readAddress  in  READ_PORTS*ADDR_WIDTH  port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- readData  out  READ_PORTS*DATA_WIDTH  port p uses bits [p*DATA_WIDTH +: DATA_WIDTH]
- readBusy  out  READ_PORTS  port p: 1 = value not yet final (producer outstanding)
- regWrite  in  1  writeback strobe
- writeAddress  in  ADDR_WIDTH  writeback destination
- writeData  in  DATA_WIDTH  writeback value
- reserve  in  1  issue strobe: one more write to reserveAddress is now outstanding
- reserveAddress  in  ADDR_WIDTH  destination being reserved
- reserveStall  out  1  reserve target counter is saturated; the reserve is dropped

## Operation
- State:
  - registers[0..depth-1], DATA_WIDTH each.
  - pend[0..depth-1], PEND_WIDTH each.
- Reset (resetN low, asynchronous):
  - All registers and pend counters clear to 0.
  - Outputs while in reset: readData = 0, readBusy = 0, reserveStall = 0.
- Write: on clk rising edge with regWrite = 1, registers[writeAddress] takes writeData.
  - Exception: writeAddress = 0 with ZERO_REG = 1 is ignored.
- Read (combinational, per port p, evaluated in priority order):
  - Address 0 with ZERO_REG = 1: data 0, busy 0.
  - Otherwise, regWrite = 1 and writeAddress equals the address: data = writeData (write-first bypass).
  - Otherwise: data = registers[address].
- Busy (per port p):
  - busy = (pend[a] - hit) != 0, where hit = regWrite and writeAddress == a.
  - So a port whose last outstanding producer is retiring this cycle reports busy = 0 with the bypassed data.
- Scoreboard update per clk edge, for address a:
  - Reserve only, count below max: pend[a] increments by 1.
  - Reserve only, count at max: count unchanged; reserveStall = 1 (combinational) and the reserve is dropped.
  - Write only, count nonzero: pend[a] decrements by 1.
  - Write only, count 0: count stays 0 (no underflow); the data write still occurs.
  - Reserve and write to the same address in one cycle: count unchanged (net zero).
    - Reserve is never stalled in this case, even at max.
  - Reserve and write to different addresses: each is applied independently.
- ZERO_REG = 1: reserves and writes to address 0 have no effect on pend[0]; reserveStall stays 0 for address 0.
- Reserve with regWrite low has no data effect.

## Timing
- Read: zero-cycle combinational latency from readAddress, regWrite, writeAddress or writeData to readData and readBusy.
- Write: visible through the bypass in the same cycle; visible from storage starting the cycle after the edge.
- Reserve: visible on readBusy starting the cycle after the edge.
- reserveStall: combinational from reserve, reserveAddress, regWrite, writeAddress and pend.
- Reset asserted mid-operation: clears state immediately, regardless of clk. The first update happens on the first clk edge after resetN rises.
- No handshake on the write port; the writeback stage is trusted.

## Test plan
- Reset then read all 32 addresses: every readData = 0 and readBusy = 0. Assert resetN low mid-run after writing 0xDEADBEEF to r5: r5 reads 0 immediately.
- Write 0x12345678 to r7 while port 0 reads r7 in the same cycle: readData = 0x12345678 that cycle and all later cycles. Write to r0: r0 still reads 0.
- Reserve r3 at cycle 0, then read r3:
  - Cycle 1: busy = 1.
  - Cycle 5: write r3 = 0xA5, readBusy = 0 with data 0xA5 in that same cycle.
  - Cycle 6 onward: busy = 0.
- Reserve r9 three times (PEND_WIDTH = 2):
  - Fourth reserve: reserveStall = 1 and count stays at 3.
  - Three writes to r9: busy clears only on the third.
  - A fourth write: count stays 0 and the data is updated.
- Reserve r4 and write r4 in the same cycle, with pend[r4] = 3: no stall, count stays 3, data updated.
- READ_PORTS = 4 build: four ports read r1, r2, r1 and r0 concurrently while a write to r2 occurs. Each port returns the correct data and busy independently.
